rat_ckpt: RTL and testbench

Parametrised CAM-style register alias table with branch checkpoints. It sits between rename and commit. It provides free physical-register allocation, per-group mapping creation and source lookup with intra-group bypass, commit/release bookkeeping, and single-cycle recovery to any live checkpoint without walking the ROB.

---
 rtl/rat_ckpt.sv | 244 ++++++++++++++++++++++++
 tb/tb_rat_ckpt.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_ckpt.sv
// Register alias table with per-phy arch tags, free-list scan, intra-group
// bypass lookup and branch checkpoints with single-cycle restore.
module rat_ckpt #(
    parameter int unsigned PHY_REG_NUM    = 64,
    parameter int unsigned ARCH_REG_NUM   = 32,
    parameter int unsigned RENAME_WIDTH   = 4,
    parameter int unsigned COMMIT_WIDTH   = 4,
    parameter int unsigned CHECKPOINT_NUM = 8,
    localparam int unsigned PW = $clog2(PHY_REG_NUM),
    localparam int unsigned AW = $clog2(ARCH_REG_NUM),
    localparam int unsigned CW = $clog2(CHECKPOINT_NUM)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    output logic [RENAME_WIDTH-1:0][PW-1:0]       rat_rename_new_phy_id,
    output logic [RENAME_WIDTH-1:0]               rat_rename_new_phy_id_valid,
    input  logic [RENAME_WIDTH-1:0][PW-1:0]       rename_rat_phy_id,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]       rename_rat_arch_id,
    input  logic [RENAME_WIDTH-1:0]               rename_rat_valid,
    input  logic                                  rename_rat_map,
    input  logic [RENAME_WIDTH-1:0][2:0][AW-1:0]  rename_rat_read_arch_id,
    output logic [RENAME_WIDTH-1:0][2:0][PW-1:0]  rat_rename_read_phy_id,
    input  logic                                  rename_rat_ckpt_req,
    output logic                                  rat_rename_ckpt_ready,
    output logic [CW-1:0]                         rat_rename_ckpt_id,
    input  logic                                  exu_rat_ckpt_restore,
    input  logic [CW-1:0]                         exu_rat_ckpt_restore_id,
    input  logic                                  commit_rat_ckpt_release,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]       commit_rat_release_phy_id,
    input  logic [COMMIT_WIDTH-1:0]               commit_rat_release_valid,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]       commit_rat_commit_phy_id,
    input  logic [COMMIT_WIDTH-1:0]               commit_rat_commit_valid,
    input  logic                                  commit_rat_flush,
    input  logic [PHY_REG_NUM-1:0]                commit_rat_flush_valid,
    input  logic [PHY_REG_NUM-1:0]                commit_rat_flush_visible
);

    localparam int unsigned CNTW = CW + 1;

    logic [AW-1:0]          arch_q [PHY_REG_NUM];
    logic [AW-1:0]          arch_d [PHY_REG_NUM];
    logic [PHY_REG_NUM-1:0] valid_q, valid_d;
    logic [PHY_REG_NUM-1:0] visible_q, visible_d;
    logic [PHY_REG_NUM-1:0] committed_q, committed_d;

    logic [PHY_REG_NUM-1:0] snap_visible_q [CHECKPOINT_NUM];
    logic [PHY_REG_NUM-1:0] snap_visible_d [CHECKPOINT_NUM];
    logic [PHY_REG_NUM-1:0] snap_valid_q   [CHECKPOINT_NUM];
    logic [PHY_REG_NUM-1:0] snap_valid_d   [CHECKPOINT_NUM];
    logic [PHY_REG_NUM-1:0] alloc_mask_q   [CHECKPOINT_NUM];
    logic [PHY_REG_NUM-1:0] alloc_mask_d   [CHECKPOINT_NUM];

    logic [CW-1:0]   head_q, head_d;
    logic [CW-1:0]   tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;

    logic                   take;
    logic [PHY_REG_NUM-1:0] wr_mask;

    assign rat_rename_ckpt_ready = (count_q < CNTW'(CHECKPOINT_NUM));
    assign rat_rename_ckpt_id    = tail_q;

    // Free-list scan: lowest-index invalid phys fill slots in order; phy 0 is never handed out.
    always_comb begin : alloc_scan
        int n;
        n = 0;
        rat_rename_new_phy_id       = '0;
        rat_rename_new_phy_id_valid = '0;
        for (int p = 1; p < PHY_REG_NUM; p++) begin
            if (!valid_q[p]) begin
                for (int j = 0; j < RENAME_WIDTH; j++) begin
                    if (n == j) begin
                        rat_rename_new_phy_id[j]       = PW'(p);
                        rat_rename_new_phy_id_valid[j] = 1'b1;
                    end
                end
                n = n + 1;
            end
        end
    end

    // Source lookup: youngest earlier channel in the group overrides the visible mapping.
    always_comb begin : lookup
        logic [AW-1:0] a;
        logic [PW-1:0] res;
        rat_rename_read_phy_id = '0;
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            for (int r = 0; r < 3; r++) begin
                a   = rename_rat_read_arch_id[j][r];
                res = '0;
                if (a != '0) begin
                    for (int p = 0; p < PHY_REG_NUM; p++) begin
                        if (valid_q[p] && visible_q[p] && arch_q[p] == a) begin
                            res = PW'(p);
                        end
                    end
                    for (int i = 0; i < j; i++) begin
                        if (rename_rat_valid[i] && rename_rat_arch_id[i] == a) begin
                            res = rename_rat_phy_id[i];
                        end
                    end
                end
                rat_rename_read_phy_id[j][r] = res;
            end
        end
    end

    always_comb begin : next_state
        logic [CW-1:0] rel;
        logic          youngest;
        valid_d        = valid_q;
        visible_d      = visible_q;
        committed_d    = committed_q;
        arch_d         = arch_q;
        snap_visible_d = snap_visible_q;
        snap_valid_d   = snap_valid_q;
        alloc_mask_d   = alloc_mask_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        take           = 1'b0;
        wr_mask        = '0;
        rel            = '0;
        youngest       = 1'b0;

        for (int j = 0; j < RENAME_WIDTH; j++) begin
            if (rename_rat_valid[j] && rename_rat_arch_id[j] != '0) begin
                wr_mask[rename_rat_phy_id[j]] = 1'b1;
            end
        end

        if (commit_rat_flush) begin
            valid_d   = commit_rat_flush_valid;
            visible_d = commit_rat_flush_visible;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            // Restore drops everything allocated since the snapshot and discards younger slots.
            if (exu_rat_ckpt_restore) begin
                valid_d   = valid_q & ~alloc_mask_q[exu_rat_ckpt_restore_id];
                visible_d = snap_visible_q[exu_rat_ckpt_restore_id] & valid_d;
                tail_d    = exu_rat_ckpt_restore_id;
                count_d   = CNTW'(CW'(exu_rat_ckpt_restore_id - head_q));
            end

            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_rat_release_valid[k]) begin
                    valid_d[commit_rat_release_phy_id[k]]     = 1'b0;
                    visible_d[commit_rat_release_phy_id[k]]   = 1'b0;
                    committed_d[commit_rat_release_phy_id[k]] = 1'b0;
                end
                if (commit_rat_commit_valid[k]) begin
                    committed_d[commit_rat_commit_phy_id[k]] = 1'b1;
                end
            end

            if (!exu_rat_ckpt_restore) begin
                if (commit_rat_ckpt_release && count_q != '0) begin
                    head_d  = head_q + CW'(1);
                    count_d = count_d - CNTW'(1);
                end

                if (rename_rat_map) begin
                    for (int j = 0; j < RENAME_WIDTH; j++) begin
                        if (rename_rat_valid[j] && rename_rat_arch_id[j] != '0) begin
                            for (int p = 0; p < PHY_REG_NUM; p++) begin
                                if (visible_q[p] && arch_q[p] == rename_rat_arch_id[j]) begin
                                    visible_d[p] = 1'b0;
                                end
                            end
                        end
                    end
                    for (int j = 0; j < RENAME_WIDTH; j++) begin
                        if (rename_rat_valid[j] && rename_rat_arch_id[j] != '0) begin
                            youngest = 1'b1;
                            for (int k = j + 1; k < RENAME_WIDTH; k++) begin
                                if (rename_rat_valid[k] && rename_rat_arch_id[k] == rename_rat_arch_id[j]) begin
                                    youngest = 1'b0;
                                end
                            end
                            valid_d[rename_rat_phy_id[j]]     = 1'b1;
                            committed_d[rename_rat_phy_id[j]] = 1'b0;
                            arch_d[rename_rat_phy_id[j]]      = rename_rat_arch_id[j];
                            visible_d[rename_rat_phy_id[j]]   = youngest;
                        end
                    end
                    for (int s = 0; s < CHECKPOINT_NUM; s++) begin
                        rel = CW'(s) - head_q;
                        if (CNTW'(rel) < count_q) begin
                            alloc_mask_d[s] = alloc_mask_q[s] | wr_mask;
                        end
                    end
                    if (rename_rat_ckpt_req && rat_rename_ckpt_ready) begin
                        take    = 1'b1;
                        tail_d  = tail_q + CW'(1);
                        count_d = count_d + CNTW'(1);
                    end
                end
            end
        end

        // The new slot captures the post-group mapping and starts with an empty alloc mask.
        if (take) begin
            snap_visible_d[tail_q] = visible_d;
            snap_valid_d[tail_q]   = valid_d;
            alloc_mask_d[tail_q]   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PHY_REG_NUM; p++) begin
                arch_q[p]      <= (p >= 1 && p < ARCH_REG_NUM) ? AW'(p) : '0;
                valid_q[p]     <= (p >= 1 && p < ARCH_REG_NUM);
                visible_q[p]   <= (p >= 1 && p < ARCH_REG_NUM);
                committed_q[p] <= (p >= 1 && p < ARCH_REG_NUM);
            end
            for (int s = 0; s < CHECKPOINT_NUM; s++) begin
                snap_visible_q[s] <= '0;
                snap_valid_q[s]   <= '0;
                alloc_mask_q[s]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (!commit_rat_flush && exu_rat_ckpt_restore) begin
                assert (CNTW'(CW'(exu_rat_ckpt_restore_id - head_q)) < count_q);
            end
            arch_q         <= arch_d;
            valid_q        <= valid_d;
            visible_q      <= visible_d;
            committed_q    <= committed_d;
            snap_visible_q <= snap_visible_d;
            snap_valid_q   <= snap_valid_d;
            alloc_mask_q   <= alloc_mask_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
        end
    end

endmodule

// File: tb/tb_rat_ckpt.sv
// Bench for rat_ckpt: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model of the alias table.
module tb_rat_ckpt;

    localparam int unsigned PN = 64;
    localparam int unsigned AN = 32;
    localparam int unsigned RW = 4;
    localparam int unsigned CMW = 4;
    localparam int unsigned CK = 8;
    localparam int unsigned PW = 6;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 3;

    logic clk;
    logic rst;
    logic [RW-1:0][PW-1:0]      new_id;
    logic [RW-1:0]              new_v;
    logic [RW-1:0][PW-1:0]      ren_phy;
    logic [RW-1:0][AW-1:0]      ren_arch;
    logic [RW-1:0]              ren_v;
    logic                       ren_map;
    logic [RW-1:0][2:0][AW-1:0] rd_arch;
    logic [RW-1:0][2:0][PW-1:0] rd_phy;
    logic                       ck_req;
    logic                       ck_ready;
    logic [CW-1:0]              ck_id;
    logic                       rs;
    logic [CW-1:0]              rs_id;
    logic                       ck_rel;
    logic [CMW-1:0][PW-1:0]     rel_id;
    logic [CMW-1:0]             rel_v;
    logic [CMW-1:0][PW-1:0]     com_id;
    logic [CMW-1:0]             com_v;
    logic                       fl;
    logic [PN-1:0]              fl_valid;
    logic [PN-1:0]              fl_vis;

    rat_ckpt dut (
        .clk                          (clk),
        .rst                          (rst),
        .rat_rename_new_phy_id        (new_id),
        .rat_rename_new_phy_id_valid  (new_v),
        .rename_rat_phy_id            (ren_phy),
        .rename_rat_arch_id           (ren_arch),
        .rename_rat_valid             (ren_v),
        .rename_rat_map               (ren_map),
        .rename_rat_read_arch_id      (rd_arch),
        .rat_rename_read_phy_id       (rd_phy),
        .rename_rat_ckpt_req          (ck_req),
        .rat_rename_ckpt_ready        (ck_ready),
        .rat_rename_ckpt_id           (ck_id),
        .exu_rat_ckpt_restore         (rs),
        .exu_rat_ckpt_restore_id      (rs_id),
        .commit_rat_ckpt_release      (ck_rel),
        .commit_rat_release_phy_id    (rel_id),
        .commit_rat_release_valid     (rel_v),
        .commit_rat_commit_phy_id     (com_id),
        .commit_rat_commit_valid      (com_v),
        .commit_rat_flush             (fl),
        .commit_rat_flush_valid       (fl_valid),
        .commit_rat_flush_visible     (fl_vis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: per-phy tags plus a queue of live checkpoints, oldest at the front.
    typedef struct packed {
        logic [PN-1:0] vis;
        logic [PN-1:0] alloc;
    } snap_t;

    logic [AW-1:0] m_arch [PN];
    logic [PN-1:0] m_valid, m_vis, m_comm;
    snap_t         m_ck [$];
    int            m_head;

    int errors;
    int checks;

    task automatic model_reset();
        for (int p = 0; p < PN; p++) begin
            m_arch[p]  = (p >= 1 && p < AN) ? AW'(p) : '0;
            m_valid[p] = (p >= 1 && p < AN);
            m_vis[p]   = (p >= 1 && p < AN);
            m_comm[p]  = (p >= 1 && p < AN);
        end
        m_ck.delete();
        m_head = 0;
    endtask

    task automatic model_commit_release();
        for (int k = 0; k < CMW; k++) begin
            if (rel_v[k]) begin
                m_valid[rel_id[k]] = 1'b0;
                m_vis[rel_id[k]]   = 1'b0;
                m_comm[rel_id[k]]  = 1'b0;
            end
        end
        for (int k = 0; k < CMW; k++) begin
            if (com_v[k]) m_comm[com_id[k]] = 1'b1;
        end
    endtask

    task automatic model_edge();
        int            idx;
        bit            do_take;
        bit            latest;
        logic [PN-1:0] wm;
        logic [PN-1:0] hide;
        snap_t         s;
        if (rst) begin
            model_reset();
        end else if (fl) begin
            m_valid = fl_valid;
            m_vis   = fl_vis;
            m_ck.delete();
            m_head  = 0;
        end else if (rs) begin
            idx     = (int'(rs_id) - m_head + int'(CK)) % int'(CK);
            m_valid = m_valid & ~m_ck[idx].alloc;
            m_vis   = m_ck[idx].vis & m_valid;
            while (m_ck.size() > idx) void'(m_ck.pop_back());
            model_commit_release();
        end else begin
            model_commit_release();
            do_take = ren_map && ck_req && (m_ck.size() < int'(CK));
            if (ren_map) begin
                wm   = '0;
                hide = '0;
                for (int j = 0; j < RW; j++) begin
                    if (ren_v[j] && ren_arch[j] != 0) begin
                        wm[ren_phy[j]] = 1'b1;
                        for (int p = 0; p < PN; p++)
                            if (m_vis[p] && m_arch[p] == ren_arch[j]) hide[p] = 1'b1;
                    end
                end
                m_vis = m_vis & ~hide;
                for (int j = 0; j < RW; j++) begin
                    if (ren_v[j] && ren_arch[j] != 0) begin
                        latest = 1'b1;
                        for (int k = j + 1; k < RW; k++)
                            if (ren_v[k] && ren_arch[k] == ren_arch[j]) latest = 1'b0;
                        m_valid[ren_phy[j]] = 1'b1;
                        m_comm[ren_phy[j]]  = 1'b0;
                        m_arch[ren_phy[j]]  = ren_arch[j];
                        m_vis[ren_phy[j]]   = latest;
                    end
                end
                for (int i = 0; i < m_ck.size(); i++) begin
                    s       = m_ck[i];
                    s.alloc = s.alloc | wm;
                    m_ck[i] = s;
                end
            end
            if (ck_rel && m_ck.size() > 0) begin
                void'(m_ck.pop_front());
                m_head = (m_head + 1) % int'(CK);
            end
            if (do_take) begin
                s.vis   = m_vis;
                s.alloc = '0;
                m_ck.push_back(s);
            end
        end
    endtask

    task automatic m_free(output logic [RW-1:0][PW-1:0] ids, output logic [RW-1:0] v);
        int n;
        ids = '0;
        v   = '0;
        n   = 0;
        for (int p = 1; p < PN; p++) begin
            if (!m_valid[p] && n < RW) begin
                ids[n] = PW'(p);
                v[n]   = 1'b1;
                n++;
            end
        end
    endtask

    function automatic logic [PW-1:0] m_lookup(int j, logic [AW-1:0] a);
        logic [PW-1:0] r;
        bit            found;
        r     = '0;
        found = 1'b0;
        if (a == 0) return '0;
        for (int i = j - 1; i >= 0; i--) begin
            if (!found && ren_v[i] && ren_arch[i] == a) begin
                r     = ren_phy[i];
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int p = 0; p < PN; p++)
                if (m_valid[p] && m_vis[p] && m_arch[p] == a) r = PW'(p);
        end
        return r;
    endfunction

    task automatic idle();
        ren_phy  = '0;
        ren_arch = '0;
        ren_v    = '0;
        ren_map  = 1'b0;
        rd_arch  = '0;
        ck_req   = 1'b0;
        rs       = 1'b0;
        rs_id    = '0;
        ck_rel   = 1'b0;
        rel_id   = '0;
        rel_v    = '0;
        com_id   = '0;
        com_v    = '0;
        fl       = 1'b0;
        fl_valid = '0;
        fl_vis   = '0;
    endtask

    // Advance one edge; the model consumes the same inputs the DUT saw.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [RW-1:0][PW-1:0] exp_ids;
        do_reset();
        rd_arch[0][0] = AW'(5);
        rd_arch[1][1] = AW'(0);
        #1;
        exp_ids = {PW'(35), PW'(34), PW'(33), PW'(32)};
        checks++;
        if (new_id !== exp_ids) begin errors++; $display("FAIL reset_new_id: got %h expected %h", new_id, exp_ids); end
        checks++;
        if (new_v !== 4'hF) begin errors++; $display("FAIL reset_new_valid: got %b expected 1111", new_v); end
        checks++;
        if (rd_phy[0][0] !== PW'(5)) begin errors++; $display("FAIL reset_read_a5: got %0d expected 5", rd_phy[0][0]); end
        checks++;
        if (rd_phy[1][1] !== PW'(0)) begin errors++; $display("FAIL reset_read_a0: got %0d expected 0", rd_phy[1][1]); end
        checks++;
        if (ck_ready !== 1'b1 || ck_id !== 3'd0) begin errors++; $display("FAIL reset_ckpt: got ready=%b id=%0d expected ready=1 id=0", ck_ready, ck_id); end
    endtask

    task automatic test_bypass();
        do_reset();
        ren_map     = 1'b1;
        ren_v       = 4'b0101;
        ren_arch[0] = AW'(3); ren_phy[0] = PW'(32);
        ren_arch[2] = AW'(3); ren_phy[2] = PW'(34);
        rd_arch[3][0] = AW'(3);
        rd_arch[1][0] = AW'(3);
        rd_arch[0][0] = AW'(3);
        #1;
        checks++;
        if (rd_phy[3][0] !== PW'(34)) begin errors++; $display("FAIL bypass_ch3: got %0d expected 34", rd_phy[3][0]); end
        checks++;
        if (rd_phy[1][0] !== PW'(32)) begin errors++; $display("FAIL bypass_ch1: got %0d expected 32", rd_phy[1][0]); end
        checks++;
        if (rd_phy[0][0] !== PW'(3)) begin errors++; $display("FAIL bypass_ch0: got %0d expected 3", rd_phy[0][0]); end
        tick();
        idle();
        rd_arch[0][0] = AW'(3);
        #1;
        checks++;
        if ({dut.visible_q[3], dut.visible_q[32], dut.visible_q[34]} !== 3'b001) begin
            errors++; $display("FAIL bypass_visible: got %b expected 001", {dut.visible_q[3], dut.visible_q[32], dut.visible_q[34]});
        end
        checks++;
        if (rd_phy[0][0] !== PW'(34)) begin errors++; $display("FAIL bypass_after: got %0d expected 34", rd_phy[0][0]); end
    endtask

    task automatic test_restore();
        do_reset();
        ren_map = 1'b1; ren_v = 4'b0001; ren_arch[0] = AW'(7); ren_phy[0] = PW'(32); ck_req = 1'b1;
        #1;
        checks++;
        if (ck_id !== 3'd0) begin errors++; $display("FAIL restore_take_id: got %0d expected 0", ck_id); end
        tick();
        idle();
        ren_map = 1'b1; ren_v = 4'b0001; ren_arch[0] = AW'(7); ren_phy[0] = PW'(33);
        tick();
        idle();
        rs = 1'b1; rs_id = 3'd0;
        ren_map = 1'b1; ren_v = 4'b0001; ren_arch[0] = AW'(12); ren_phy[0] = PW'(34);
        tick();
        idle();
        rd_arch[0][0] = AW'(7);
        #1;
        checks++;
        if (dut.valid_q[33] !== 1'b0 || dut.valid_q[34] !== 1'b0) begin errors++; $display("FAIL restore_valid: got v33=%b v34=%b expected 0 0", dut.valid_q[33], dut.valid_q[34]); end
        checks++;
        if (rd_phy[0][0] !== PW'(32)) begin errors++; $display("FAIL restore_read_a7: got %0d expected 32", rd_phy[0][0]); end
        checks++;
        if (dut.count_q !== 4'd0) begin errors++; $display("FAIL restore_count: got %0d expected 0", dut.count_q); end
        checks++;
        if (new_id[0] !== PW'(33)) begin errors++; $display("FAIL restore_new_id: got %0d expected 33", new_id[0]); end
    endtask

    task automatic test_ckpt_full();
        do_reset();
        for (int i = 0; i < CK; i++) begin
            ren_map = 1'b1; ck_req = 1'b1;
            #1;
            checks++;
            if (ck_ready !== 1'b1 || ck_id !== CW'(i)) begin errors++; $display("FAIL full_take%0d: got ready=%b id=%0d expected ready=1 id=%0d", i, ck_ready, ck_id, i); end
            tick();
        end
        #1;
        checks++;
        if (ck_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", ck_ready); end
        tick();
        checks++;
        if (dut.count_q !== 4'd8) begin errors++; $display("FAIL full_9th: got count %0d expected 8", dut.count_q); end
        ck_rel = 1'b1;
        tick();
        ck_rel = 1'b0;
        #1;
        checks++;
        if (dut.count_q !== 4'd7 || dut.head_q !== 3'd1) begin errors++; $display("FAIL full_release: got count=%0d head=%0d expected 7 1", dut.count_q, dut.head_q); end
        checks++;
        if (ck_ready !== 1'b1 || ck_id !== 3'd0) begin errors++; $display("FAIL full_wrap: got ready=%b id=%0d expected 1 0", ck_ready, ck_id); end
        tick();
        checks++;
        if (dut.count_q !== 4'd8 || dut.tail_q !== 3'd1) begin errors++; $display("FAIL full_wrap_take: got count=%0d tail=%0d expected 8 1", dut.count_q, dut.tail_q); end
    endtask

    task automatic test_commit_restore();
        do_reset();
        ren_map = 1'b1; ren_v = 4'b0001; ren_arch[0] = AW'(3); ren_phy[0] = PW'(32); ck_req = 1'b1;
        tick();
        idle();
        com_v[0] = 1'b1; com_id[0] = PW'(32);
        rel_v[0] = 1'b1; rel_id[0] = PW'(3);
        tick();
        idle();
        #1;
        checks++;
        if (new_id[0] !== PW'(3)) begin errors++; $display("FAIL commit_realloc: got %0d expected 3", new_id[0]); end
        ren_map = 1'b1; ren_v = 4'b0001; ren_arch[0] = AW'(9); ren_phy[0] = PW'(3);
        tick();
        idle();
        checks++;
        if (dut.valid_q[3] !== 1'b1) begin errors++; $display("FAIL commit_alloc3: got %b expected 1", dut.valid_q[3]); end
        rs = 1'b1; rs_id = 3'd0;
        tick();
        idle();
        rd_arch[0][0] = AW'(3);
        rd_arch[0][1] = AW'(9);
        #1;
        checks++;
        if (dut.valid_q[3] !== 1'b0) begin errors++; $display("FAIL commit_restore_v3: got %b expected 0", dut.valid_q[3]); end
        checks++;
        if (rd_phy[0][0] !== PW'(32) || dut.committed_q[32] !== 1'b1) begin errors++; $display("FAIL commit_restore_a3: got %0d c=%b expected 32 1", rd_phy[0][0], dut.committed_q[32]); end
        checks++;
        if (rd_phy[0][1] !== PW'(9)) begin errors++; $display("FAIL commit_restore_a9: got %0d expected 9", rd_phy[0][1]); end
    endtask

    task automatic test_flush_restore();
        logic [PN-1:0] fv;
        do_reset();
        ren_map = 1'b1; ren_v = 4'b0001; ren_arch[0] = AW'(4); ren_phy[0] = PW'(32); ck_req = 1'b1;
        tick();
        idle();
        fv       = 64'h0000_0000_FFFF_FFFE;
        fl       = 1'b1;
        fl_valid = fv;
        fl_vis   = fv;
        rs       = 1'b1;
        rs_id    = 3'd0;
        tick();
        idle();
        rd_arch[2][2] = AW'(4);
        #1;
        checks++;
        if (dut.valid_q !== fv || dut.visible_q !== fv) begin errors++; $display("FAIL flush_vectors: got v=%h vis=%h expected %h", dut.valid_q, dut.visible_q, fv); end
        checks++;
        if (dut.count_q !== 4'd0 || dut.head_q !== 3'd0 || ck_id !== 3'd0) begin errors++; $display("FAIL flush_ckpt: got count=%0d head=%0d tail=%0d expected 0 0 0", dut.count_q, dut.head_q, ck_id); end
        checks++;
        if (rd_phy[2][2] !== PW'(4)) begin errors++; $display("FAIL flush_read_a4: got %0d expected 4", rd_phy[2][2]); end
    endtask

    task automatic test_random();
        logic [RW-1:0][PW-1:0] fr;
        logic [RW-1:0]         fv;
        logic [PW-1:0]         exp_p;
        int                    r;
        int                    p;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            m_free(fr, fv);
            r = int'($urandom_range(0, 99));
            if (r < 5 && m_ck.size() > 0) begin
                rs    = 1'b1;
                rs_id = CW'((m_head + int'($urandom_range(0, m_ck.size() - 1))) % int'(CK));
            end else if (r == 5) begin
                fl       = 1'b1;
                fl_valid = m_valid & {$urandom, $urandom};
                fl_vis   = fl_valid & m_vis;
            end
            ren_map = ($urandom_range(0, 9) < 7);
            for (int j = 0; j < RW; j++) begin
                ren_v[j]    = fv[j] && ($urandom_range(0, 3) != 0);
                ren_phy[j]  = fr[j];
                ren_arch[j] = AW'($urandom_range(0, AN - 1));
                for (int k = 0; k < 3; k++) rd_arch[j][k] = AW'($urandom_range(0, AN - 1));
            end
            ck_req = ($urandom_range(0, 9) < 3);
            ck_rel = ($urandom_range(0, 99) < 15);
            for (int k = 0; k < 2; k++) begin
                p = int'($urandom_range(1, PN - 1));
                if (m_valid[p] && !m_vis[p] && $urandom_range(0, 9) < 7) begin
                    rel_v[k]  = 1'b1;
                    rel_id[k] = PW'(p);
                end
                p = int'($urandom_range(1, PN - 1));
                if (m_valid[p] && m_vis[p] && !m_comm[p]) begin
                    com_v[k]  = 1'b1;
                    com_id[k] = PW'(p);
                end
            end
            #1;
            checks++;
            if (new_id !== fr || new_v !== fv) begin errors++; $display("FAIL rnd_alloc c%0d: got %h/%b expected %h/%b", c, new_id, new_v, fr, fv); end
            checks++;
            if (ck_ready !== (m_ck.size() < int'(CK)) || ck_id !== CW'((m_head + m_ck.size()) % int'(CK))) begin
                errors++; $display("FAIL rnd_ckpt c%0d: got ready=%b id=%0d expected size=%0d head=%0d", c, ck_ready, ck_id, m_ck.size(), m_head);
            end
            for (int j = 0; j < RW; j++) begin
                for (int k = 0; k < 3; k++) begin
                    exp_p = m_lookup(j, rd_arch[j][k]);
                    checks++;
                    if (rd_phy[j][k] !== exp_p) begin errors++; $display("FAIL rnd_read c%0d ch%0d.%0d arch%0d: got %0d expected %0d", c, j, k, rd_arch[j][k], rd_phy[j][k], exp_p); end
                end
            end
            tick();
            checks++;
            if (dut.valid_q !== m_valid || dut.visible_q !== m_vis || dut.committed_q !== m_comm) begin
                errors++; $display("FAIL rnd_state c%0d: got v=%h vis=%h c=%h expected v=%h vis=%h c=%h", c, dut.valid_q, dut.visible_q, dut.committed_q, m_valid, m_vis, m_comm);
            end
            checks++;
            if (dut.count_q !== 4'(m_ck.size()) || dut.head_q !== CW'(m_head)) begin
                errors++; $display("FAIL rnd_ptrs c%0d: got count=%0d head=%0d expected %0d %0d", c, dut.count_q, dut.head_q, m_ck.size(), m_head);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_bypass();
        test_restore();
        test_ckpt_full();
        test_commit_restore();
        test_flush_restore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
